sim_window_argmax: RTL

Sits directly downstream of the per-pixel similarity stage, which produces 255 - |op1 - op2| per pixel pair.
- Accumulates WIN_LEN consecutive 8-bit similarity samples into a window score for each of NUM_CAND candidate positions (disparities / offsets).
- Tracks the candidate with the highest score and reports its index and score with a one-cycle done pulse.
- The search controller drives start and qualifies each similarity sample with sim_valid.

---
 rtl/sim_window_argmax_pkg.sv | 23 ++
 rtl/sim_window_argmax_win_accum.sv | 37 +++
 rtl/sim_window_argmax.sv | 104 ++++++++++
 3 files changed

// File: rtl/sim_window_argmax_pkg.sv
// Shared types for the window-score search: FSM state encoding and the
// width derivations used by the controller and neighbouring stages.
package sim_window_argmax_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // A window of all-255 samples needs exactly this many bits, so sums never wrap.
  function automatic int sum_width(input int win_len);
    return SAMPLE_W + $clog2(win_len);
  endfunction

  function automatic int idx_width(input int num_cand);
    return (num_cand > 1) ? $clog2(num_cand) : 1;
  endfunction

endpackage

// File: rtl/sim_window_argmax_win_accum.sv
// Window accumulator: sums enabled samples; acc updates on the edge after en.
// No backpressure of its own; clr wins over en, last flags the final sample slot.
module sim_window_argmax_win_accum
  import sim_window_argmax_pkg::*;
#(
  parameter int WIN_LEN = 16,
  parameter int SUM_W   = sum_width(WIN_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SUM_W-1:0]    acc,
  output logic                last
);

  localparam int CNT_W = $clog2(WIN_LEN);

  logic [CNT_W-1:0] sample_cnt;

  assign last = (sample_cnt == CNT_W'(WIN_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (clr) begin
      acc        <= '0;
      sample_cnt <= '0;
    end else if (en) begin
      acc        <= acc + SUM_W'(sample);
      sample_cnt <= last ? '0 : sample_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sim_window_argmax.sv
// Best-window search: per candidate WIN_LEN accepted samples + 1 compare cycle, done one cycle later.
// sim_ready is high only while accumulating; samples offered at other times are dropped.
module sim_window_argmax
  import sim_window_argmax_pkg::*;
#(
  parameter int WIN_LEN  = 16,
  parameter int NUM_CAND = 8,
  parameter int SUM_W    = sum_width(WIN_LEN),
  parameter int IDX_W    = idx_width(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sim_valid,
  input  logic [SAMPLE_W-1:0] sim_in,
  output logic                sim_ready,
  output logic                busy,
  output logic [IDX_W-1:0]    cand_idx,
  output logic                done,
  output logic [IDX_W-1:0]    best_idx,
  output logic [SUM_W-1:0]    best_score
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cand_cnt;
  logic [SUM_W-1:0]   acc;
  logic               acc_clr, acc_en, acc_last;
  logic               best_upd, last_cand;

  assign cand_idx  = cand_cnt;
  assign last_cand = (cand_cnt == IDX_W'(NUM_CAND - 1));

  sim_window_argmax_win_accum #(
    .WIN_LEN (WIN_LEN),
    .SUM_W   (SUM_W)
  ) u_win_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .sample (sim_in),
    .acc    (acc),
    .last   (acc_last)
  );

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    best_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = sim_valid && sim_ready;
        if (acc_en && acc_last) state_nxt = COMPARE;
      end
      COMPARE: begin
        // Strict greater-than keeps the lowest index on ties.
        best_upd = (cand_cnt == '0) || (acc > best_score);
        if (last_cand) begin
          state_nxt = DONE;
        end else begin
          acc_clr   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cand_cnt   <= '0;
      best_idx   <= '0;
      best_score <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sim_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      sim_ready <= (state_nxt == ACCUM);
      if (state == IDLE && start) begin
        cand_cnt   <= '0;
        best_idx   <= '0;
        best_score <= '0;
      end
      if (best_upd) begin
        best_score <= acc;
        best_idx   <= cand_cnt;
      end
      if (state == COMPARE && !last_cand) cand_cnt <= cand_cnt + IDX_W'(1);
    end
  end

endmodule
